// File: rtl/bcrypt_core_out_serializer.sv
// Core-side result buffer and 1-bit LSB-first frame transmitter drained by the bcrypt arbiter.
// A frame is a start bit, two header words and, depending on mode_cmp/cmp_result, sixteen data words.
module bcrypt_core_out_serializer #(
   parameter int HASH_NUM_W  = 2,
   parameter int START_DELAY = 2
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  mode_cmp,
   input  logic                  wr_en,
   input  logic [3:0]            wr_addr,
   input  logic [15:0]           din,
   input  logic                  cmp_result,
   input  logic [HASH_NUM_W-1:0] hash_num,
   input  logic                  commit,
   output logic                  ready,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  dout,
   output logic                  err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FULL,
      S_DELAY,
      S_START,
      S_HDR0,
      S_HDR1,
      S_DATA
   } state_t;

   localparam logic [3:0]  DELAY_LAST = 4'(START_DELAY);
   localparam logic [15:0] HDR1_WORD  = 16'h00BC;

   state_t                  state_q, state_d;
   logic [3:0]              dly_cnt_q, dly_cnt_d;
   logic [3:0]              bit_idx_q, bit_idx_d;
   logic [3:0]              word_idx_q, word_idx_d;
   logic                    cmp_r_q, cmp_r_d;
   logic [HASH_NUM_W-1:0]   hash_num_r_q, hash_num_r_d;
   logic                    mode_q, mode_d;
   logic                    dout_q, dout_d;
   logic                    ready_q, ready_d;
   logic                    empty_q, empty_d;
   logic                    err_q, err_d;
   logic [15:0]             buf_q [16];
   logic [15:0]             hdr0;
   logic                    buf_wr;

   assign buf_wr = wr_en & ready_q;

   always_comb begin
      hdr0                     = '0;
      hdr0[5]                  = cmp_r_q;
      hdr0[6 +: HASH_NUM_W]    = hash_num_r_q;
   end

   // dout_d is derived from the next state so that dout stays a pure register output.
   always_comb begin
      state_d      = state_q;
      dly_cnt_d    = dly_cnt_q;
      bit_idx_d    = bit_idx_q;
      word_idx_d   = word_idx_q;
      cmp_r_d      = cmp_r_q;
      hash_num_r_d = hash_num_r_q;
      mode_d       = mode_q;
      err_d        = err_q | ((wr_en | commit) & ~ready_q);

      unique case (state_q)
         S_IDLE: begin
            if (commit) begin
               state_d      = S_FULL;
               cmp_r_d      = cmp_result;
               hash_num_r_d = hash_num;
            end
         end
         S_FULL: begin
            if (rd_en) begin
               state_d   = S_DELAY;
               dly_cnt_d = 4'd1;
               mode_d    = mode_cmp;
            end
         end
         S_DELAY: begin
            if (dly_cnt_q == DELAY_LAST) begin
               state_d   = S_START;
               dly_cnt_d = 4'd0;
            end else begin
               dly_cnt_d = dly_cnt_q + 4'd1;
            end
         end
         S_START: begin
            state_d   = S_HDR0;
            bit_idx_d = 4'd2;
         end
         S_HDR0: begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd15) begin
               state_d = S_HDR1;
            end
         end
         S_HDR1: begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd15) begin
               word_idx_d = 4'd0;
               state_d    = (~mode_q | cmp_r_q) ? S_DATA : S_IDLE;
            end
         end
         S_DATA: begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd15) begin
               word_idx_d = word_idx_q + 4'd1;
               if (word_idx_q == 4'd15) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_START: dout_d = 1'b1;
         S_HDR0:  dout_d = hdr0[bit_idx_d];
         S_HDR1:  dout_d = HDR1_WORD[bit_idx_d];
         S_DATA:  dout_d = buf_q[word_idx_d][bit_idx_d];
         default: dout_d = 1'b0;
      endcase

      ready_d = (state_d == S_IDLE);
      empty_d = (state_d != S_FULL);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q      <= S_IDLE;
         dly_cnt_q    <= '0;
         bit_idx_q    <= '0;
         word_idx_q   <= '0;
         cmp_r_q      <= 1'b0;
         hash_num_r_q <= '0;
         mode_q       <= 1'b0;
         dout_q       <= 1'b0;
         ready_q      <= 1'b1;
         empty_q      <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dly_cnt_q    <= dly_cnt_d;
         bit_idx_q    <= bit_idx_d;
         word_idx_q   <= word_idx_d;
         cmp_r_q      <= cmp_r_d;
         hash_num_r_q <= hash_num_r_d;
         mode_q       <= mode_d;
         dout_q       <= dout_d;
         ready_q      <= ready_d;
         empty_q      <= empty_d;
         err_q        <= err_d;
      end
   end

   // Buffer contents are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge CLK) begin
      if (buf_wr) begin
         buf_q[wr_addr] <= din;
      end
   end

   assign ready = ready_q;
   assign empty = empty_q;
   assign dout  = dout_q;
   assign err   = err_q;

endmodule

// File: tb/tb_bcrypt_core_out_serializer.sv
// Scoreboard bench for bcrypt_core_out_serializer: expected frame bits are queued when a read
// is issued and popped one per cycle against dout.
module tb_bcrypt_core_out_serializer;

   localparam int HNW = 2;
   localparam int SD  = 2;

   logic           CLK = 1'b0;
   logic           rst;
   logic           mode_cmp;
   logic           wr_en;
   logic [3:0]     wr_addr;
   logic [15:0]    din;
   logic           cmp_result;
   logic [HNW-1:0] hash_num;
   logic           commit;
   logic           ready;
   logic           rd_en;
   logic           empty;
   logic           dout;
   logic           err;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          frame_len;
   bit          exp_q[$];
   logic [15:0] words [16];

   bcrypt_core_out_serializer #(.HASH_NUM_W(HNW), .START_DELAY(SD)) dut (
      .CLK(CLK), .rst(rst), .mode_cmp(mode_cmp), .wr_en(wr_en), .wr_addr(wr_addr),
      .din(din), .cmp_result(cmp_result), .hash_num(hash_num), .commit(commit),
      .ready(ready), .rd_en(rd_en), .empty(empty), .dout(dout), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Loads all sixteen words, then commits with the given header fields.
   task automatic applyStimulus(input bit cmp, input logic [HNW-1:0] hash);
      for (int k = 0; k < 16; k++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(k);
         din     = words[k];
         tick();
      end
      wr_en      = 1'b0;
      commit     = 1'b1;
      cmp_result = cmp;
      hash_num   = hash;
      tick();
      commit     = 1'b0;
      cmp_result = 1'b0;
      hash_num   = '0;
      checkOutput("empty_after_commit", 32'(empty), 32'd0);
      checkOutput("ready_after_commit", 32'(ready), 32'd0);
   endtask

   task automatic build_frame(input bit mode, input bit cmp, input logic [HNW-1:0] hash);
      logic [15:0] h0;
      logic [15:0] h1;
      bit          send;
      h0       = 16'h0000;
      h0[5]    = cmp;
      h0[7:6]  = hash;
      h1       = 16'h00BC;
      send     = !mode || cmp;
      exp_q.delete();
      repeat (SD) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      for (int i = 2; i < 16; i++) exp_q.push_back(h0[i]);
      for (int i = 0; i < 16; i++) exp_q.push_back(h1[i]);
      if (send)
         for (int w = 0; w < 16; w++)
            for (int b = 0; b < 16; b++) exp_q.push_back(words[w][b]);
      repeat (4) exp_q.push_back(1'b0);
      frame_len = send ? 287 : 31;
   endtask

   // Issues rd_en and drains the scoreboard; optionally disturbs mid-frame or aborts with rst.
   task automatic run_frame(input bit mode, input int abort_at, input bit disturb);
      int idx;
      bit b;
      mode_cmp = mode;
      rd_en    = 1'b1;
      tick();
      rd_en    = 1'b0;
      checkOutput("empty_after_rd", 32'(empty), 32'd1);
      idx = 0;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         checkOutput($sformatf("dout[%0d]", idx), 32'(dout), 32'(b));
         if (idx == SD + frame_len - 1) checkOutput("ready_last_bit", 32'(ready), 32'd0);
         if (idx == SD + frame_len)     checkOutput("ready_after_frame", 32'(ready), 32'd1);
         idx++;
         if (idx == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkOutput("abort_dout", 32'(dout), 32'd0);
            checkOutput("abort_ready", 32'(ready), 32'd1);
            checkOutput("abort_empty", 32'(empty), 32'd1);
            checkOutput("abort_err", 32'(err), 32'd0);
            exp_q.delete();
            return;
         end
         if (disturb) begin
            if (idx == 10) mode_cmp = ~mode;
            if (idx == 40) commit = 1'b1;
            if (idx == 60) begin
               wr_en   = 1'b1;
               wr_addr = 4'd4;
               din     = 16'hFFFF;
            end
            if (idx == 80) rd_en = 1'b1;
         end
         tick();
         commit   = 1'b0;
         wr_en    = 1'b0;
         rd_en    = 1'b0;
         mode_cmp = mode;
      end
   endtask

   initial begin
      bit seen_high;
      rst = 1'b1; mode_cmp = 1'b0; wr_en = 1'b0; wr_addr = '0; din = '0;
      cmp_result = 1'b0; hash_num = '0; commit = 1'b0; rd_en = 1'b0;
      tick();
      rst = 1'b0;
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_dout", 32'(dout), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);

      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      seen_high = 1'b0;
      repeat (400) begin
         if (dout !== 1'b0) seen_high = 1'b1;
         tick();
      end
      checkOutput("idle_rd_dout", 32'(seen_high), 32'd0);
      checkOutput("idle_rd_err", 32'(err), 32'd0);

      for (int k = 0; k < 16; k++) words[k] = 16'h1000 + 16'(k);
      applyStimulus(1'b0, 2'd2);
      build_frame(1'b0, 1'b0, 2'd2);
      run_frame(1'b0, -1, 1'b0);

      applyStimulus(1'b0, 2'd1);
      build_frame(1'b1, 1'b0, 2'd1);
      run_frame(1'b1, -1, 1'b0);
      checkOutput("hdr_only_empty", 32'(empty), 32'd1);

      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      applyStimulus(1'b1, 2'd3);
      build_frame(1'b1, 1'b1, 2'd3);
      run_frame(1'b1, -1, 1'b0);

      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      applyStimulus(1'b0, 2'd0);
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      din     = ~words[0];
      tick();
      wr_en = 1'b0;
      checkOutput("err_wr_full", 32'(err), 32'd1);
      checkOutput("empty_still_full", 32'(empty), 32'd0);
      build_frame(1'b0, 1'b0, 2'd0);
      run_frame(1'b0, -1, 1'b1);
      checkOutput("err_sticky", 32'(err), 32'd1);

      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      applyStimulus(1'b1, 2'd2);
      build_frame(1'b0, 1'b1, 2'd2);
      run_frame(1'b0, SD + 132, 1'b0);

      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      applyStimulus(1'b0, 2'd1);
      build_frame(1'b0, 1'b0, 2'd1);
      run_frame(1'b0, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
